stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Run/pause/lap/clear controller for the stopwatch datapath. Generates its own 0.1 s enable tick from the system clock and sequences an mm:ss.t time counter through a four-state FSM. Outputs binary time fields (live or lap-frozen) for the downstream display/BCD stage. All logic is in one clock domain; there are no derived clocks.

## Interface
- TICK_DIV, 5_000_000, system clock cycles per 0.1 s tick (must be ≥ 2)
- MAX_MIN, 99, highest minute value before wrap (≤ 127)

- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start_stop  in  1  single-cycle command pulse; toggles run/pause
- clear  in  1  single-cycle command pulse; return to zero/IDLE
- lap  in  1  single-cycle command pulse; freeze/unfreeze display
- disp_tenth  out  4  displayed tenths, 0–9
- disp_sec  out  6  displayed seconds, 0–59
- disp_min  out  7  displayed minutes, 0–MAX_MIN
- running  out  1  high in RUN or LAP
- lap_hold  out  1  high in LAP (display frozen)
- overflow  out  1  sticky; set on wrap past MAX_MIN:59.9

## Operation
- The FSM has four states: IDLE, RUN, PAUSE, LAP. Encoding is free.
- Command priority per cycle is clear > start_stop > lap. A lower-priority pulse in the same cycle is dropped.
- Transitions:
  - IDLE: start_stop → RUN. lap is ignored.
  - RUN: start_stop → PAUSE. lap → LAP; the display snapshot is taken.
  - LAP: lap → RUN; the display returns to live. start_stop → PAUSE; the display returns to live.
  - PAUSE: start_stop → RUN. lap is ignored.
  - clear in any state → IDLE. Time counters, snapshot, prescaler and overflow are all zeroed.
- Prescaler behaviour:
  - Counts 0..TICK_DIV-1 in RUN and LAP.
  - tick = (prescaler == TICK_DIV-1) while in RUN/LAP. On a tick the prescaler wraps to 0.
  - Held at its current value in PAUSE, so the phase is preserved across pause.
  - Held at 0 in IDLE.
- Time counter, advanced on each tick:
  - tenth increments. At 9 it goes to 0 and carries to sec.
  - sec at 59 goes to 0 and carries to min.
  - min at MAX_MIN with a carry goes to 0, and overflow is set. Overflow stays set until clear or reset.
- The time counter is not advanced in IDLE or PAUSE.
- Display outputs:
  - In LAP, disp_* show the snapshot registers.
  - In all other states, disp_* show the live counters.

## Timing
- Reset (rst_n low at a posedge) gives:
  - state IDLE
  - all disp_* = 0
  - running = 0, lap_hold = 0, overflow = 0
  - prescaler = 0, snapshot = 0
- All outputs are registered.
- Command latency: a command pulse sampled at edge N changes state/outputs visible after edge N. running and lap_hold follow state with no extra delay.
- First tick after IDLE→RUN at edge N occurs at edge N+TICK_DIV. Live time changes after that edge.
- Tick and start_stop in RUN at the same edge: the tick is counted and the state goes to PAUSE. The displayed value includes the increment.
- Tick and lap in RUN at the same edge: the snapshot captures the post-increment value.
- Tick in LAP: the live counter advances and disp_* are unchanged.
- Tick and clear at the same edge: clear wins and all fields are 0.
- rst_n low mid-run overrides all commands and ticks in that cycle.
- Command inputs are not debounced or edge-detected here; pulses longer than one cycle act once per cycle high.

## Configuration
- STOPWATCH_LAP_EN defined:
  - The LAP state, snapshot registers and lap input are active, as described above.
- STOPWATCH_LAP_EN undefined:
  - The lap input is ignored and LAP is unreachable.
  - No snapshot registers are built.
  - lap_hold is tied 0 and disp_* always show the live counters.
  - All other behaviour is identical.

## Test plan
All scenarios use TICK_DIV=4 and MAX_MIN=99 unless noted.
- Reset then idle: rst_n low 2 cycles, then 20 cycles idle → all outputs 0, running=0.
- Run count: start_stop at edge 0, then 40 cycles → disp 00:01.0 at edge 40, running=1.
- Pause phase hold: start_stop at 0, start_stop at 6 (pause), hold 10 cycles, start_stop at 16 → next tick at edge 18 (prescaler resumed from 2). Ticks at 4 and 18 give disp_tenth=2 after edge 18.
- Lap freeze (LAP_EN): run, lap coincident with the tick at edge 12 → disp_tenth frozen at 3 while live advances. lap at edge 40 → disp shows live 00:01.0.
- Wrap and overflow: MAX_MIN=0, run 600 ticks → after tick 599 disp 00:59.9; after tick 600 disp 00:00.0 and overflow=1 sticky. clear → overflow=0, IDLE.
- Priority: clear, start_stop and lap all pulsed in the same RUN cycle → IDLE, all zero. start_stop and lap together in RUN → PAUSE, lap_hold=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer for an mm:ss.t stopwatch.
// A built-in prescaler produces the 0.1 s tick. A four-state FSM gates that
// tick into a tenth/second/minute counter, which wraps and sets a sticky
// overflow flag. Every output is registered.
// Optional feature macro: STOPWATCH_LAP_EN. When it is defined, the LAP state
// and the snapshot registers are built. When it is undefined, lap is ignored.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 5_000_000,
    parameter int MAX_MIN  = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] disp_tenth,
    output logic [5:0] disp_sec,
    output logic [6:0] disp_min,
    output logic       running,
    output logic       lap_hold,
    output logic       overflow
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]     MIN_LAST   = 7'(MAX_MIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tenth_q, tenth_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    min_q, min_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    disp_tenth_q, disp_tenth_d;
    logic [5:0]    disp_sec_q, disp_sec_d;
    logic [6:0]    disp_min_q, disp_min_d;
    logic          running_q, running_d;
    logic          lap_hold_q, lap_hold_d;

    logic          active;
    logic          tick;
    logic          lap_cmd;

`ifdef STOPWATCH_LAP_EN
    logic [3:0]    snap_tenth_q, snap_tenth_d;
    logic [5:0]    snap_sec_q, snap_sec_d;
    logic [6:0]    snap_min_q, snap_min_d;

    assign lap_cmd = lap;
`else
    logic          unused_lap;

    assign lap_cmd    = 1'b0;
    assign unused_lap = lap;
`endif

    // The counter only runs in RUN and LAP. A tick fires when the prescaler reaches its last count.
    assign active = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick   = active && (presc_q == PRESC_LAST);

    // Next-state logic. clear beats start_stop, and start_stop beats lap.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else if (start_stop) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                S_LAP:   state_d = S_PAUSE;
                default: state_d = S_IDLE;
            endcase
        end else if (lap_cmd) begin
            case (state_q)
                S_RUN:   state_d = S_LAP;
                S_LAP:   state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath. The prescaler keeps its phase in PAUSE.
    // A tick advances tenths, which carry into seconds and then into minutes.
    always_comb begin
        presc_d = presc_q;
        tenth_d = tenth_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        if (clear) begin
            presc_d = '0;
            tenth_d = '0;
            sec_d   = '0;
            min_d   = '0;
            ovf_d   = 1'b0;
        end else if (active) begin
            if (tick) begin
                presc_d = '0;
                if (tenth_q == 4'd9) begin
                    tenth_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == MIN_LAST) begin
                            min_d = '0;
                            ovf_d = 1'b1;
                        end else begin
                            min_d = min_q + 7'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    tenth_d = tenth_q + 4'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (state_q == S_IDLE) begin
            presc_d = '0;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Snapshot. It captures the post-tick live time when RUN moves to LAP.
    always_comb begin
        snap_tenth_d = snap_tenth_q;
        snap_sec_d   = snap_sec_q;
        snap_min_d   = snap_min_q;
        if (clear) begin
            snap_tenth_d = '0;
            snap_sec_d   = '0;
            snap_min_d   = '0;
        end else if ((state_q == S_RUN) && (state_d == S_LAP)) begin
            snap_tenth_d = tenth_d;
            snap_sec_d   = sec_d;
            snap_min_d   = min_d;
        end
    end
`endif

    // Output logic. It is computed from next-state values so the registered outputs line up with the state.
    always_comb begin
        running_d    = (state_d == S_RUN) || (state_d == S_LAP);
        lap_hold_d   = 1'b0;
        disp_tenth_d = tenth_d;
        disp_sec_d   = sec_d;
        disp_min_d   = min_d;
`ifdef STOPWATCH_LAP_EN
        if (state_d == S_LAP) begin
            lap_hold_d   = 1'b1;
            disp_tenth_d = snap_tenth_d;
            disp_sec_d   = snap_sec_d;
            disp_min_d   = snap_min_d;
        end
`endif
    end

    // State register, counters and output registers. Reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            tenth_q      <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            ovf_q        <= 1'b0;
            disp_tenth_q <= '0;
            disp_sec_q   <= '0;
            disp_min_q   <= '0;
            running_q    <= 1'b0;
            lap_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tenth_q      <= tenth_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            ovf_q        <= ovf_d;
            disp_tenth_q <= disp_tenth_d;
            disp_sec_q   <= disp_sec_d;
            disp_min_q   <= disp_min_d;
            running_q    <= running_d;
            lap_hold_q   <= lap_hold_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Snapshot registers. They are cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_tenth_q <= '0;
            snap_sec_q   <= '0;
            snap_min_q   <= '0;
        end else begin
            snap_tenth_q <= snap_tenth_d;
            snap_sec_q   <= snap_sec_d;
            snap_min_q   <= snap_min_d;
        end
    end
`endif

    assign disp_tenth = disp_tenth_q;
    assign disp_sec   = disp_sec_q;
    assign disp_min   = disp_min_q;
    assign running    = running_q;
    assign lap_hold   = lap_hold_q;
    assign overflow   = ovf_q;

endmodule
